// File: rtl/shade_dither_pack.sv
// Ordered-dither and BGR555 pack stage: 4x4 dither, clamp, truncate to 5 bits, 2-stage valid/ready pipe.
// Optional pixel/saturation statistics counters are enabled by defining SHADE_PIXSTAT_EN.
module shade_dither_pack #(
    parameter int XW = 10,
    parameter int YW = 9
) (
    input  logic          clk,
    input  logic          i_nrst,
    input  logic          i_valid,
    output logic          o_ready,
    input  logic [7:0]    i_r,
    input  logic [7:0]    i_g,
    input  logic [7:0]    i_b,
    input  logic [XW-1:0] i_x,
    input  logic [YW-1:0] i_y,
    input  logic          i_stp,
    input  logic          i_ditherEn,
    input  logic          i_forceMask,
    output logic          o_valid,
    input  logic          i_ready,
    output logic [15:0]   o_pix,
    output logic [XW-1:0] o_x,
    output logic [YW-1:0] o_y
`ifdef SHADE_PIXSTAT_EN
    ,
    input  logic          i_statClr,
    output logic [31:0]   o_pixCount,
    output logic [31:0]   o_satCount
`endif
);

    logic                adv;
    logic signed [3:0]   dither_val;
    logic                s1_valid;
    logic [XW-1:0]       s1_x;
    logic [YW-1:0]       s1_y;
    logic                s1_mask;
    logic signed [9:0]   s1_r;
    logic signed [9:0]   s1_g;
    logic signed [9:0]   s1_b;

    function automatic logic signed [3:0] dither_offset(input logic [1:0] row, input logic [1:0] col);
        logic signed [3:0] d;
        case ({row, col})
            4'h0: d = -4'sd4;  4'h1: d = 4'sd0;   4'h2: d = -4'sd3;  4'h3: d = 4'sd1;
            4'h4: d = 4'sd2;   4'h5: d = -4'sd2;  4'h6: d = 4'sd3;   4'h7: d = -4'sd1;
            4'h8: d = -4'sd3;  4'h9: d = 4'sd1;   4'hA: d = -4'sd4;  4'hB: d = 4'sd0;
            4'hC: d = 4'sd3;   4'hD: d = -4'sd1;  4'hE: d = 4'sd2;   default: d = -4'sd2;
        endcase
        return d;
    endfunction

    function automatic logic signed [9:0] add_dither(input logic [7:0] c, input logic signed [3:0] d);
        return $signed({2'b00, c}) + $signed({{6{d[3]}}, d});
    endfunction

    // Sums span -4..258, so bit 9 flags underflow and bit 8 flags overflow.
    function automatic logic [4:0] clamp5(input logic signed [9:0] s);
        logic [4:0] q;
        if (s[9])
            q = 5'h00;
        else if (s[8])
            q = 5'h1F;
        else
            q = s[7:3];
        return q;
    endfunction

    assign adv        = !o_valid || i_ready;
    assign o_ready    = adv;
    assign dither_val = i_ditherEn ? dither_offset(i_y[1:0], i_x[1:0]) : 4'sd0;

    always_ff @(posedge clk or negedge i_nrst) begin
        if (!i_nrst) begin
            s1_valid <= 1'b0;
            s1_x     <= '0;
            s1_y     <= '0;
            s1_mask  <= 1'b0;
            s1_r     <= '0;
            s1_g     <= '0;
            s1_b     <= '0;
        end else if (adv) begin
            s1_valid <= i_valid;
            if (i_valid) begin
                s1_x    <= i_x;
                s1_y    <= i_y;
                s1_mask <= i_stp | i_forceMask;
                s1_r    <= add_dither(i_r, dither_val);
                s1_g    <= add_dither(i_g, dither_val);
                s1_b    <= add_dither(i_b, dither_val);
            end
        end
    end

    always_ff @(posedge clk or negedge i_nrst) begin
        if (!i_nrst) begin
            o_valid <= 1'b0;
            o_pix   <= '0;
            o_x     <= '0;
            o_y     <= '0;
        end else if (adv) begin
            o_valid <= s1_valid;
            if (s1_valid) begin
                o_pix <= {s1_mask, clamp5(s1_b), clamp5(s1_g), clamp5(s1_r)};
                o_x   <= s1_x;
                o_y   <= s1_y;
            end
        end
    end

`ifdef SHADE_PIXSTAT_EN
    logic s2_sat;
    logic handshake;

    assign handshake = o_valid && i_ready;

    always_ff @(posedge clk or negedge i_nrst) begin
        if (!i_nrst)
            s2_sat <= 1'b0;
        else if (adv && s1_valid)
            s2_sat <= s1_r[9] | s1_r[8] | s1_g[9] | s1_g[8] | s1_b[9] | s1_b[8];
    end

    // Clear has priority over a coincident handshake.
    always_ff @(posedge clk or negedge i_nrst) begin
        if (!i_nrst) begin
            o_pixCount <= '0;
            o_satCount <= '0;
        end else if (i_statClr) begin
            o_pixCount <= '0;
            o_satCount <= '0;
        end else if (handshake) begin
            o_pixCount <= o_pixCount + 32'd1;
            if (s2_sat)
                o_satCount <= o_satCount + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_shade_dither_pack.sv
// Self-checking bench for shade_dither_pack: spec vectors, stall/stream sequences, random traffic vs a queue model.
// Define SHADE_PIXSTAT_EN to also exercise the statistics counters.
module tb_shade_dither_pack;

    logic        clk = 1'b0;
    logic        i_nrst;
    logic        i_valid;
    logic        o_ready;
    logic [7:0]  i_r, i_g, i_b;
    logic [9:0]  i_x;
    logic [8:0]  i_y;
    logic        i_stp, i_ditherEn, i_forceMask;
    logic        o_valid;
    logic        i_ready;
    logic [15:0] o_pix;
    logic [9:0]  o_x;
    logic [8:0]  o_y;
    logic        stat_clr;
`ifdef SHADE_PIXSTAT_EN
    logic [31:0] o_pixCount, o_satCount;
`endif

    shade_dither_pack #(.XW(10), .YW(9)) dut (
        .clk(clk), .i_nrst(i_nrst), .i_valid(i_valid), .o_ready(o_ready),
        .i_r(i_r), .i_g(i_g), .i_b(i_b), .i_x(i_x), .i_y(i_y),
        .i_stp(i_stp), .i_ditherEn(i_ditherEn), .i_forceMask(i_forceMask),
        .o_valid(o_valid), .i_ready(i_ready), .o_pix(o_pix), .o_x(o_x), .o_y(o_y)
`ifdef SHADE_PIXSTAT_EN
        , .i_statClr(stat_clr), .o_pixCount(o_pixCount), .o_satCount(o_satCount)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] pix;
        logic [31:0] x;
        logic [31:0] y;
        bit          sat;
    } exp_t;

    typedef struct {
        int          r, g, b, x, y;
        bit          stp, dith, fm;
        logic [15:0] exp_pix;
    } vec_t;

    localparam int DM [4][4] = '{'{-4, 0, -3, 1}, '{2, -2, 3, -1}, '{-3, 1, -4, 0}, '{3, -1, 2, -2}};

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   out_count = 0;
    int   m_pix = 0;
    int   m_sat = 0;
    bit   last_accept;

    // Reference model: dither, clamp to 0..255, divide by 8, pack as mask|B|G|R.
    function automatic exp_t model(input int r, g, b, x, y, input bit stp, dith, fm);
        exp_t e;
        int   ch[3];
        int   q5[3];
        int   d;
        int   v;
        ch    = '{r, g, b};
        d     = dith ? DM[y % 4][x % 4] : 0;
        e.sat = 0;
        for (int i = 0; i < 3; i++) begin
            v = ch[i] + d;
            if (v < 0) begin
                v = 0;
                e.sat = 1;
            end else if (v > 255) begin
                v = 255;
                e.sat = 1;
            end
            q5[i] = v / 8;
        end
        e.pix = 16'(((stp || fm) ? 32768 : 0) + q5[2] * 1024 + q5[1] * 32 + q5[0]);
        e.x   = 32'(x);
        e.y   = 32'(y);
        return e;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // One cycle: drive at the falling edge, then check outputs against the model and advance it.
    task automatic applyStimulus(input bit v, rd, input int r, g, b, x, y,
                                 input bit stp, dith, fm, clr);
        bit hs;
        bit hs_sat;
        @(negedge clk);
        i_valid = v; i_ready = rd;
        i_r = 8'(r); i_g = 8'(g); i_b = 8'(b);
        i_x = 10'(x); i_y = 9'(y);
        i_stp = stp; i_ditherEn = dith; i_forceMask = fm; stat_clr = clr;
        #1;
        checkOutput("o_ready_rule", 32'(o_ready), 32'(!o_valid || i_ready));
        if (o_valid) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_output actual o_pix=%h required no output", o_pix);
            end else begin
                checkOutput("sb_pix", 32'(o_pix), 32'(q[0].pix));
                checkOutput("sb_x", 32'(o_x), q[0].x);
                checkOutput("sb_y", 32'(o_y), q[0].y);
            end
        end
`ifdef SHADE_PIXSTAT_EN
        checkOutput("pixCount", o_pixCount, 32'(m_pix));
        checkOutput("satCount", o_satCount, 32'(m_sat));
`endif
        hs = 0;
        hs_sat = 0;
        if (o_valid && i_ready && q.size() > 0) begin
            hs = 1;
            hs_sat = q[0].sat;
            void'(q.pop_front());
            out_count++;
        end
        if (clr) begin
            m_pix = 0;
            m_sat = 0;
        end else if (hs) begin
            m_pix++;
            if (hs_sat) m_sat++;
        end
        last_accept = i_valid && o_ready;
        if (last_accept) q.push_back(model(r, g, b, x, y, stp, dith, fm));
    endtask

    task automatic idle();
        applyStimulus(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic applyReset();
        @(negedge clk);
        i_nrst = 1'b0;
        i_valid = 1'b0;
        #1;
        checkOutput("rst_valid", 32'(o_valid), 0);
        checkOutput("rst_pix", 32'(o_pix), 0);
        q.delete();
        m_pix = 0;
        m_sat = 0;
        @(negedge clk);
        i_nrst = 1'b1;
    endtask

    task automatic drain();
        for (int k = 0; k < 40 && q.size() > 0; k++) idle();
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL drain_timeout actual pending=%0d required 0", q.size());
        end
    endtask

    initial begin
        vec_t vecs[6];
        bit   pat[8];
        int   acc;
        int   base;
        int   acc_total;

        vecs[0] = '{r:100, g:100, b:100, x:0,  y:0, stp:0, dith:1, fm:0, exp_pix:16'h318C};
        vecs[1] = '{r:255, g:128, b:7,   x:5,  y:7, stp:0, dith:0, fm:1, exp_pix:16'h821F};
        vecs[2] = '{r:255, g:255, b:255, x:3,  y:0, stp:0, dith:1, fm:0, exp_pix:16'h7FFF};
        vecs[3] = '{r:2,   g:2,   b:2,   x:0,  y:0, stp:0, dith:1, fm:0, exp_pix:16'h0000};
        vecs[4] = '{r:50,  g:60,  b:70,  x:2,  y:1, stp:1, dith:1, fm:0, exp_pix:16'hA4E6};
        vecs[5] = '{r:8,   g:16,  b:24,  x:11, y:6, stp:0, dith:1, fm:0, exp_pix:16'h0C41};
        pat = '{1, 0, 0, 1, 0, 1, 1, 0};

        i_nrst = 1'b0; i_valid = 0; i_ready = 1; stat_clr = 0;
        i_r = 0; i_g = 0; i_b = 0; i_x = 0; i_y = 0;
        i_stp = 0; i_ditherEn = 0; i_forceMask = 0;
        #1;
        checkOutput("init_valid", 32'(o_valid), 0);
        checkOutput("init_pix", 32'(o_pix), 0);
        checkOutput("init_x", 32'(o_x), 0);
        checkOutput("init_y", 32'(o_y), 0);
        repeat (2) @(negedge clk);
        i_nrst = 1'b1;

        for (int i = 0; i < 6; i++) begin
            applyStimulus(1, 1, vecs[i].r, vecs[i].g, vecs[i].b, vecs[i].x, vecs[i].y,
                          vecs[i].stp, vecs[i].dith, vecs[i].fm, 0);
            idle();
            checkOutput($sformatf("vec%0d_early", i), 32'(o_valid), 0);
            idle();
            checkOutput($sformatf("vec%0d_valid", i), 32'(o_valid), 1);
            checkOutput($sformatf("vec%0d_pix", i), 32'(o_pix), 32'(vecs[i].exp_pix));
            checkOutput($sformatf("vec%0d_x", i), 32'(o_x), 32'(vecs[i].x));
            checkOutput($sformatf("vec%0d_y", i), 32'(o_y), 32'(vecs[i].y));
`ifdef SHADE_PIXSTAT_EN
            if (i == 3) begin
                idle();
                checkOutput("stat_pix4", o_pixCount, 4);
                checkOutput("stat_sat2", o_satCount, 2);
            end
`endif
        end
        drain();

`ifdef SHADE_PIXSTAT_EN
        applyStimulus(1, 1, 255, 0, 0, 3, 0, 0, 1, 0, 0);
        idle();
        applyStimulus(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        idle();
        checkOutput("clr_pix", o_pixCount, 0);
        checkOutput("clr_sat", o_satCount, 0);
`endif

        base = out_count;
        acc  = 0;
        for (int k = 0; k < 200 && (acc < 8 || q.size() > 0); k++) begin
            applyStimulus(acc < 8, pat[k % 8], 20 * acc, 255 - 20 * acc, 7 * acc, acc, 3,
                          0, 1, 0, 0);
            if (last_accept) acc++;
        end
        checkOutput("stream8_count", 32'(out_count - base), 8);
        drain();

        base = out_count;
        acc_total = 0;
        for (int k = 0; k < 400; k++) begin
            applyStimulus(($urandom % 4) != 0, ($urandom % 3) != 0,
                          $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255),
                          $urandom_range(0, 1023), $urandom_range(0, 511),
                          1'($urandom), 1'($urandom), 1'($urandom % 5 == 0), 1'($urandom % 64 == 0));
            if (last_accept) acc_total++;
        end
        drain();
        checkOutput("random_count", 32'(out_count - base), 32'(acc_total));

        applyStimulus(1, 1, 10, 20, 30, 1, 1, 0, 1, 0, 0);
        applyStimulus(1, 1, 40, 50, 60, 2, 1, 0, 1, 0, 0);
        applyReset();
        for (int k = 0; k < 5; k++) begin
            idle();
            checkOutput("post_rst_valid", 32'(o_valid), 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
